// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [2:0] FETCH_SIZE = 3'b010;

    typedef enum logic [1:0] {
        EXC_NONE   = 2'd0,
        EXC_MALIGN = 2'd1,
        EXC_FAULT  = 2'd2
    } fetch_exc_e;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        fetch_exc_e  exc;
    } fetch_entry_t;

    // Misalignment outranks the bus fault when both are flagged.
    function automatic fetch_exc_e resp_exc(input logic malign, input logic fault);
        if (malign)
            return EXC_MALIGN;
        else if (fault)
            return EXC_FAULT;
        else
            return EXC_NONE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO between fetch and decode; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  entry_t     din,
    output logic [1:0] count,
    output entry_t     head,
    output logic       valid
);

    logic   rd_ptr;
    logic   wr_ptr;
    logic   pop_ok;
    entry_t mem [2];

    assign valid  = (count != 2'd0);
    assign pop_ok = pop && valid;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop_ok)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    // When full, a same-cycle pop vacates exactly the slot wr_ptr points at.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads, buffers responses, hands them to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   AddrWidth   = 32,
    parameter int                   DataWidth   = 32,
    parameter logic [AddrWidth-1:0] ResetVector = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [AddrWidth-1:0] mem_address,
    output logic [2:0]           mem_sign_size,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic                 mem_complete,
    input  logic [DataWidth-1:0] mem_rdata,
    input  logic                 mem_malign,
    input  logic                 mem_fault,
    input  logic                 redirect,
    input  logic [AddrWidth-1:0] redirect_pc,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [DataWidth-1:0] inst,
    output logic [AddrWidth-1:0] inst_pc,
    output logic [1:0]           inst_exc
);

    typedef struct packed {
        logic [DataWidth-1:0] inst;
        logic [AddrWidth-1:0] pc;
        fetch_exc_e           exc;
    } entry_t;

    fetch_state_e         state;
    logic [AddrWidth-1:0] pc;
    logic [AddrWidth-1:0] out_pc;
    logic                 outstanding;
    logic [1:0]           fifo_count;
    logic                 fifo_valid;
    entry_t               head;
    entry_t               rsp_entry_p1;
    logic                 pop;
    logic                 push_p1;
    logic                 accept_p0;
    logic [2:0]           occupancy;

    // Request stage (p0): slots already claimed by buffered entries plus the one in flight.
    assign pop       = fifo_valid && inst_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, outstanding} - {2'b00, pop};
    assign mem_rd    = (state == RUN) && !halt_req && !redirect && rst_n && (occupancy < 3'd2);
    assign accept_p0 = mem_rd && mem_complete;

    assign mem_address   = pc;
    assign mem_sign_size = FETCH_SIZE;
    assign mem_wr        = 1'b0;
    assign mem_wdata     = '0;
    assign halted        = rst_n && halt_req && !outstanding;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= ResetVector;
            outstanding <= 1'b0;
            state       <= RUN;
        end else begin
            outstanding <= accept_p0;
            if (redirect) begin
                pc    <= redirect_pc;
                state <= RUN;
            end else begin
                if (accept_p0)
                    pc <= pc + AddrWidth'(4);
                if (push_p1 && rsp_entry_p1.exc != EXC_NONE)
                    state <= EXC_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0)
            out_pc <= pc;
    end

    // Response stage (p1): the registered bus response lands in the buffer.
    assign push_p1           = outstanding && !redirect;
    assign rsp_entry_p1.inst = mem_rdata;
    assign rsp_entry_p1.pc   = out_pc;
    assign rsp_entry_p1.exc  = resp_exc(mem_malign, mem_fault);

    fetch_fifo #(
        .entry_t(entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push_p1),
        .pop   (pop),
        .din   (rsp_entry_p1),
        .count (fifo_count),
        .head  (head),
        .valid (fifo_valid)
    );

    // Buffer data registers carry no reset, so an empty buffer presents zeros.
    assign inst_valid = fifo_valid;
    assign inst       = fifo_valid ? head.inst : '0;
    assign inst_pc    = fifo_valid ? head.pc : '0;
    assign inst_exc   = fifo_valid ? head.exc : EXC_NONE;

endmodule
